// File: rtl/newaddar_pkg.sv
// Shared types, sizes and the reference W equation for the newaddar sweep checker.
package newaddar_pkg;

   localparam int unsigned VEC_W       = 6;
   localparam int unsigned NUM_VECTORS = 64;
   localparam int unsigned ERR_W       = 7;
   localparam int unsigned WAIT_W      = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_WAIT,
      ST_CHECK,
      ST_DONE
   } state_t;

   // Vector bit order is {A,B,C,D,E,F}; A is the MSB.
   function automatic logic expected_w(input logic [VEC_W-1:0] v);
      logic a, b, c, d, e, f;
      {a, b, c, d, e, f} = v;
      return ((a & b) | (~c & d)) & (e ^ f);
   endfunction

endpackage

// File: rtl/newaddar.sv
// Golden newaddar: combinational reference producing W from an {A..F} vector.
module newaddar
   import newaddar_pkg::*;
(
   input  logic [VEC_W-1:0] vec,
   output logic             w_c
);

   assign w_c = expected_w(vec);

endmodule

// File: rtl/newaddar_checker.sv
// Exhaustive 64-vector sweep checker: drives vec_out, waits SETTLE cycles,
// compares w_in against the golden newaddar and records errors.
module newaddar_checker
   import newaddar_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             w_in,
   output logic [VEC_W-1:0] vec_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [VEC_W-1:0] first_fail,
   output logic             first_fail_valid
);

   state_t              state_q, state_d;
   logic [VEC_W-1:0]    idx_q, idx_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [VEC_W-1:0]    vec_d;
   logic [ERR_W-1:0]    err_d;
   logic [VEC_W-1:0]    ff_d;
   logic                ffv_d;
   logic                busy_d, done_d;
   logic                exp_w;

   newaddar u_golden (
      .vec (vec_out),
      .w_c (exp_w)
   );

   // State and all registered outputs; reset wins over everything.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q          <= ST_IDLE;
         idx_q            <= '0;
         wait_q           <= '0;
         vec_out          <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         err_count        <= '0;
         first_fail       <= '0;
         first_fail_valid <= 1'b0;
      end else begin
         state_q          <= state_d;
         idx_q            <= idx_d;
         wait_q           <= wait_d;
         vec_out          <= vec_d;
         busy             <= busy_d;
         done             <= done_d;
         err_count        <= err_d;
         first_fail       <= ff_d;
         first_fail_valid <= ffv_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wait_d  = wait_q;
      vec_d   = vec_out;
      err_d   = err_count;
      ff_d    = first_fail;
      ffv_d   = first_fail_valid;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_APPLY;
               idx_d   = '0;
               err_d   = '0;
               ff_d    = '0;
               ffv_d   = 1'b0;
               vec_d   = '0;
            end
         end
         ST_APPLY: begin
            wait_d  = '0;
            state_d = (SETTLE > 0) ? ST_WAIT : ST_CHECK;
         end
         ST_WAIT: begin
            if (wait_q == WAIT_W'(SETTLE - 1)) begin
               state_d = ST_CHECK;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         ST_CHECK: begin
            if (w_in != exp_w) begin
               err_d = err_count + ERR_W'(1);
               if (!first_fail_valid) begin
                  ff_d  = idx_q;
                  ffv_d = 1'b1;
               end
            end
            if (idx_q == VEC_W'(NUM_VECTORS - 1)) begin
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q + VEC_W'(1);
               vec_d   = idx_q + VEC_W'(1);
               state_d = ST_APPLY;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort overrides any in-flight check, including the last one.
      if (abort && (state_q inside {ST_APPLY, ST_WAIT, ST_CHECK})) begin
         state_d = ST_IDLE;
         idx_d   = idx_q;
         vec_d   = '0;
         err_d   = err_count;
         ff_d    = first_fail;
         ffv_d   = first_fail_valid;
      end

      busy_d = state_d inside {ST_APPLY, ST_WAIT, ST_CHECK};
      done_d = (state_d == ST_DONE);
   end

   assign pass = done && (err_count == '0);

endmodule

// File: doc/newaddar_checker.md
NEWADDAR_CHECKER -- requirements
Module: newaddar_checker

Interface
REQ-001 Parameter SETTLE, default 1: number of wait cycles between applying a vector and sampling the response (legal range 0..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  level-sampled request to begin a sweep; honoured only in IDLE or DONE.
REQ-005 abort  input  1  terminates an in-progress sweep; ignored outside a sweep.
REQ-006 vec_out  output  6  stimulus to device under test, bit order {A,B,C,D,E,F}, A = bit 5.
REQ-007 w_in  input  1  response W from the device under test.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  high while in DONE; sweep completed without abort.
REQ-010 pass  output  1  equals done AND (err_count == 0).
REQ-011 err_count  output  7  number of mismatching vectors in the current/last sweep (0..64, no saturation needed).
REQ-012 first_fail  output  6  index of the first mismatching vector; valid only when first_fail_valid is high.
REQ-013 first_fail_valid  output  1  high once any mismatch has been recorded in the current sweep.

Function
REQ-014 Expected response SHALL be W = ((A&B) | (~C&D)) & (E^F), evaluated on the current vec_out.
REQ-015 States SHALL be IDLE, APPLY, WAIT, CHECK, DONE.
REQ-016 IDLE/DONE with start=1 -> APPLY; idx, err_count, first_fail, first_fail_valid cleared; vec_out = 0.
REQ-017 APPLY (1 cycle): vec_out = idx -> WAIT if SETTLE>0, else CHECK.
REQ-018 WAIT: lasts exactly SETTLE cycles, vec_out held -> CHECK.
REQ-019 CHECK (1 cycle): on w_in != expected, increment err_count; if first_fail_valid=0, set first_fail=idx, first_fail_valid=1.
REQ-020 CHECK with idx=63 -> DONE; otherwise idx+1 -> APPLY.
REQ-021 Each vector SHALL occupy SETTLE+2 cycles; done rises exactly 64*(SETTLE+2) rising edges after the edge sampling start (192 for SETTLE=1).
REQ-022 busy SHALL be high in APPLY, WAIT, CHECK; low in IDLE and DONE.
REQ-023 start while busy SHALL be ignored.
REQ-024 abort while busy -> IDLE next edge; done stays low; err_count and first_fail fields retain values; vec_out = 0.
REQ-025 abort and a final CHECK in the same cycle: abort wins (-> IDLE, no done).
REQ-026 DONE: vec_out, err_count, first_fail held; remains until start (restart) or reset.
REQ-027 vec_out SHALL be 0 in IDLE.

Reset
REQ-028 rst_n low at a rising edge -> state IDLE, vec_out=0, idx=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, first_fail_valid=0, regardless of current state.
REQ-029 Reset SHALL take priority over start and abort.

Structure
REQ-030 Shared package newaddar_pkg SHALL hold: state enum, VEC_W=6, NUM_VECTORS=64, expected-W function.
REQ-031 One sub-module: existing newaddar instantiated as the golden model, fed from vec_out; its W is the expected value.
REQ-032 All outputs SHALL be registered except pass (derived combinationally from done and err_count).

Verification
REQ-033 Golden DUT on w_in, SETTLE=1, start pulse -> done after 192 cycles, err_count=0, pass=1, first_fail_valid=0.
REQ-034 w_in tied 0 -> err_count=14, first_fail=5 (000101), pass=0; w_in tied 1 -> err_count=50, first_fail=0.
REQ-035 SETTLE=0, golden DUT -> done after 128 cycles; SETTLE=3 -> done after 320 cycles.
REQ-036 abort at cycle 50 of sweep -> IDLE next edge, done=0, busy=0, vec_out=0; subsequent start -> full clean sweep.
REQ-037 rst_n low at cycle 100 of sweep -> all outputs at reset values next edge; start pulses during busy have no effect (done still at 192).
